pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
//   - hz_state_e : controller FSM states
//   - REG_ZERO   : hard-wired zero register index (never a hazard source)
//   - CTRL_*     : bit positions of the WB/MEM/EX control fields in the
//                  ID/EX register; a bubble clears all of them
//   - src_hits   : helper that tests one ID source operand against a
//                  destination register
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_BUBBLE = 2'd1,
    MEM_WAIT    = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // ID/EX control field layout: WB in the low bits, then MEM, then EX.
  localparam int unsigned CTRL_WB_REGWRITE = 0;
  localparam int unsigned CTRL_WB_MEMTOREG = 1;
  localparam int unsigned CTRL_MEM_READ    = 2;
  localparam int unsigned CTRL_MEM_WRITE   = 3;
  localparam int unsigned CTRL_MEM_BRANCH  = 4;
  localparam int unsigned CTRL_EX_ALUSRC   = 5;
  localparam int unsigned CTRL_EX_ALUOP_LO = 6;
  localparam int unsigned CTRL_EX_ALUOP_HI = 7;
  localparam int unsigned CTRL_EX_REGDST   = 8;
  localparam int unsigned CTRL_W           = 9;

  // Control word loaded into ID/EX: all fields cleared when flushing.
  function automatic logic [CTRL_W-1:0] idex_ctrl(input logic [CTRL_W-1:0] ctrl,
                                                  input logic              flush);
    return flush ? '0 : ctrl;
  endfunction

  function automatic logic src_hits(input logic       uses,
                                    input logic [4:0] src,
                                    input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rst : clock, asynchronous active-high reset (clears to 0)
//   clr      : synchronous clear (wins over inc)
//   inc      : add one, holding at all-ones
//   cnt      : current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage integer pipeline.
// Produces write-enable/flush controls for PC, IF/ID, ID/EX and a hold for
// EX/MEM. Event priority: memory freeze > EX redirect > load-use.
//   CLK, RESET            : clock, asynchronous active-high reset
//   id_*                  : ID-stage instruction operand usage
//   ex_*                  : EX-stage load/destination/redirect info
//   mem_req, mem_ready    : data-memory handshake from MEM stage
//   pc_write .. ex_mem_hold : combinational pipeline controls
//   mem_timeout           : sticky flag, memory wait exceeded MEM_TIMEOUT
//   stall_cycles          : saturating count of cycles with pc_write=0
//   flush_events          : saturating count of applied redirects
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 256,
  parameter int unsigned TO_W        = 9
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_regdst,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;

  logic freeze;
  logic load_use;
  logic redirect_apply;

  assign freeze = ~mem_ready & (mem_req | (state_q == MEM_WAIT));

  assign load_use = ex_valid && ex_mem_read && (ex_regdst != REG_ZERO) && id_valid &&
                    (src_hits(id_uses_rs1, id_rs1, ex_regdst) ||
                     src_hits(id_uses_rs2, id_rs2, ex_regdst));

  // A redirect seen during a freeze stays asserted (EX is frozen), so it is
  // applied and counted only in the first unfrozen cycle.
  assign redirect_apply = ex_redirect & ~freeze & ~RESET;

  always_comb begin
    state_d     = RUN;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_write = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_hold = 1'b0;
    if (RESET) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_mem_hold = 1'b1;
      state_d     = MEM_WAIT;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use && (state_q == RUN)) begin
      // Bubble goes into EX this cycle; LOAD_BUBBLE masks the same
      // hazard on the next cycle while the load moves on to MEM.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = LOAD_BUBBLE;
    end
  end

  always_comb begin
    to_cnt_d      = '0;
    mem_timeout_d = mem_timeout_q | (to_cnt_q == TO_LIMIT);
    if (state_q == MEM_WAIT) begin
      to_cnt_d = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= RUN;
      to_cnt_q      <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (CLK),
    .rst (RESET),
    .clr (1'b0),
    .inc (~pc_write),
    .cnt (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (CLK),
    .rst (RESET),
    .clr (1'b0),
    .inc (redirect_apply),
    .cnt (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]       id_rs1, id_rs2, ex_regdst;
  logic             ex_valid, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_hold;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .TO_W(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_regdst(ex_regdst),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 CLK = ~CLK;

  // Expected control bits packed as {pc_write, if_id_write, if_id_flush,
  // id_ex_write, id_ex_flush, ex_mem_hold}.
  localparam logic [5:0] C_RUN    = 6'b110100;
  localparam logic [5:0] C_LOADU  = 6'b000110;
  localparam logic [5:0] C_REDIR  = 6'b111110;
  localparam logic [5:0] C_FREEZE = 6'b000001;
  localparam logic [5:0] C_RESET  = 6'b001010;

  typedef struct {
    string      name;
    logic       idv;
    logic [4:0] rs1, rs2;
    logic       u1, u2, exv, exrd;
    logic [4:0] dst;
    logic       redir, mreq, mrdy;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(string n, logic idv, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic exv, logic exrd, logic [4:0] dst,
                              logic redir, logic mreq, logic mrdy, logic [5:0] exp);
    vec_t v;
    v.name = n; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.exv = exv; v.exrd = exrd; v.dst = dst; v.redir = redir; v.mreq = mreq;
    v.mrdy = mrdy; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctl();
    return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_hold};
  endfunction

  task automatic apply(input vec_t v);
    id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_valid = v.exv; ex_mem_read = v.exrd; ex_regdst = v.dst;
    ex_redirect = v.redir; mem_req = v.mreq; mem_ready = v.mrdy;
  endtask

  // Inputs applied just after a rising edge; outputs checked mid-cycle.
  task automatic step_chk(input vec_t v);
    apply(v);
    #2;
    chk(v.name, 32'(ctl()), 32'(v.exp));
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  vec_t idle, lu, frz_redir, frz;

  initial begin
    idle      = mk("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN);
    lu        = mk("loaduse",   1, 5, 0, 1, 0, 1, 1, 5, 0, 0, 1, C_LOADU);
    frz_redir = mk("frz_redir", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FREEZE);
    frz       = mk("frz",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FREEZE);

    tbl[0] = idle;
    tbl[1] = lu;
    tbl[2] = mk("lu_rs2",     1, 1, 7, 0, 1, 1, 1, 7, 0, 0, 1, C_LOADU);
    tbl[3] = mk("lu_x0",      1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, C_RUN);
    tbl[4] = mk("lu_nouse",   1, 5, 0, 0, 0, 1, 1, 5, 0, 0, 1, C_RUN);
    tbl[5] = mk("lu_noload",  1, 5, 0, 1, 0, 1, 0, 5, 0, 0, 1, C_RUN);
    tbl[6] = mk("lu_idinval", 0, 5, 0, 1, 0, 1, 1, 5, 0, 0, 1, C_RUN);
    tbl[7] = mk("redir_lu",   1, 5, 0, 1, 0, 1, 1, 5, 1, 0, 1, C_REDIR);
    tbl[8] = mk("req_ready",  1, 5, 0, 1, 0, 0, 0, 5, 0, 1, 1, C_RUN);
    tbl[9] = mk("frz_all",    1, 5, 0, 1, 0, 1, 1, 5, 1, 1, 0, C_FREEZE);

    // Reset state
    apply(idle);
    RESET = 1'b1;
    #2;
    chk("rst_ctl", 32'(ctl()), 32'(C_RESET));
    chk("rst_stall", 32'(stall_cycles), 0);
    chk("rst_flush", 32'(flush_events), 0);
    chk("rst_to", 32'(mem_timeout), 0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Single-cycle vectors from RUN; the idle cycle after each (mem_ready=1)
    // returns LOAD_BUBBLE and MEM_WAIT to RUN.
    for (int i = 0; i < 10; i++) begin
      step_chk(tbl[i]);
      step_chk(idle);
    end
    chk("tbl_stall", 32'(stall_cycles), 3);
    chk("tbl_flush", 32'(flush_events), 1);

    // Load-use held two cycles: second cycle is the masked bubble cycle.
    do_reset();
    step_chk(lu);
    lu.name = "bubble_masked"; lu.exp = C_RUN;
    step_chk(lu);
    chk("lu_stall", 32'(stall_cycles), 1);
    lu.name = "lu_again"; lu.exp = C_LOADU;
    step_chk(lu);
    step_chk(idle);

    // 3-cycle freeze with a pending redirect, released on the 4th cycle.
    do_reset();
    for (int i = 0; i < 3; i++) step_chk(frz_redir);
    step_chk(mk("release", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_REDIR));
    chk("frz_stall", 32'(stall_cycles), 3);
    chk("frz_flush", 32'(flush_events), 1);
    chk("frz_to", 32'(mem_timeout), 0);

    // Timeout: 6 not-ready cycles (5 in MEM_WAIT); flag is set after the
    // edge following the 4th MEM_WAIT edge.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(frz);
      #2;
      chk("frz_ctl", 32'(ctl()), 32'(C_FREEZE));
      if (i >= 4) chk("to_early", 32'(mem_timeout), 0);
      @(posedge CLK); #1;
    end
    apply(idle);
    #2;
    chk("to_set", 32'(mem_timeout), 1);
    chk("to_rel", 32'(ctl()), 32'(C_RUN));
    @(posedge CLK); #1;
    repeat (3) @(posedge CLK);
    #1;
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_stall", 32'(stall_cycles), 6);

    // Reset mid-freeze.
    step_chk(frz);
    step_chk(frz);
    #2;
    RESET = 1'b1;
    #1;
    chk("mrst_ctl", 32'(ctl()), 32'(C_RESET));
    chk("mrst_stall", 32'(stall_cycles), 0);
    chk("mrst_to", 32'(mem_timeout), 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    // Not-ready with no request would freeze only if still in MEM_WAIT.
    step_chk(mk("mrst_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN));

    // Stall counter saturation: 20 freeze cycles with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(frz);
      @(posedge CLK); #1;
    end
    chk("sat_stall", 32'(stall_cycles), 15);
    step_chk(idle);
    chk("sat_hold", 32'(stall_cycles), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
